// File: rtl/frame_receiver_pkg.sv
// Shared constants and types for the serial readout receive path.
package frame_receiver_pkg;
  localparam int WORD_W  = 12;
  localparam int N_SLOTS = 5;
  localparam int ADDR_W  = 3;

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [ADDR_W-1:0] SLOT_CH1 = 3'd0;
  localparam logic [ADDR_W-1:0] SLOT_CH2 = 3'd1;
  localparam logic [ADDR_W-1:0] SLOT_CH3 = 3'd2;
  localparam logic [ADDR_W-1:0] SLOT_CH4 = 3'd3;
  localparam logic [ADDR_W-1:0] SLOT_RTC = 3'd4;
endpackage

// File: rtl/frame_receiver_if.sv
// Link-side inputs, word/status outputs and shadow-bank read port of the receiver.
interface frame_receiver_if #(
  parameter int WORD_W = frame_receiver_pkg::WORD_W,
  parameter int ADDR_W = frame_receiver_pkg::ADDR_W
);
  logic              serial_in;
  logic              SL_in;
  logic [ADDR_W-1:0] a_in;
  logic              ovf_in;
  logic [ADDR_W-1:0] rd_sel;
  logic [WORD_W-1:0] word_out;
  logic [ADDR_W-1:0] word_addr;
  logic              word_valid;
  logic              frame_err;
  logic              addr_err;
  logic              sweep_done;
  logic [WORD_W-1:0] rd_data;
  logic              ovf_seen;

  modport master (
    output serial_in, SL_in, a_in, ovf_in, rd_sel,
    input  word_out, word_addr, word_valid, frame_err, addr_err, sweep_done,
           rd_data, ovf_seen
  );

  modport slave (
    input  serial_in, SL_in, a_in, ovf_in, rd_sel,
    output word_out, word_addr, word_valid, frame_err, addr_err, sweep_done,
           rd_data, ovf_seen
  );
endinterface

// File: rtl/frame_receiver_sipo_shift.sv
// Serial-in parallel-out shifter with bit counter; the receive twin of the transmitter PISO.
module sipo_shift #(
  parameter int WORD_W = frame_receiver_pkg::WORD_W,
  localparam int CNT_W = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] word_o,
  output logic              busy_o,
  output logic              done_o
);
  import frame_receiver_pkg::*;

  logic [WORD_W-2:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  // word_o already includes the bit being sampled, so it is complete on the done edge
  assign word_o = {shift_q, bit_i};
  assign done_o = en_i && (cnt_q == CNT_W'(WORD_W - 1));
  assign busy_o = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (en_i) begin
      shift_q <= word_o[WORD_W-2:0];
      cnt_q   <= done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/frame_receiver.sv
// Readout link receiver: deserialises addressed words into a shadow bank and flags errors/sweeps.
module frame_receiver #(
  parameter int WORD_W  = frame_receiver_pkg::WORD_W,
  parameter int N_SLOTS = frame_receiver_pkg::N_SLOTS,
  parameter int ADDR_W  = frame_receiver_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  frame_receiver_if.slave  bus
);
  import frame_receiver_pkg::*;

  localparam logic [ADDR_W-1:0] SLOT_LIM = ADDR_W'(N_SLOTS);

  state_e                          state_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [WORD_W-1:0]               word_out_q;
  logic [ADDR_W-1:0]               word_addr_q;
  logic                            word_valid_q, frame_err_q, addr_err_q, sweep_done_q;
  logic                            ovf_q;
  logic [N_SLOTS-1:0][WORD_W-1:0]  bank_q;
  logic [N_SLOTS-1:0]              mask_q;

  logic                            sipo_en, sipo_busy, sipo_done;
  logic [WORD_W-1:0]               sipo_word;
  logic [N_SLOTS-1:0]              slot_oh, mask_d;
  logic [WORD_W-1:0]               rd_d;

  assign sipo_en = (state_q == SHIFT) && !bus.SL_in;

  sipo_shift #(.WORD_W(WORD_W)) u_sipo (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (bus.SL_in),
    .en_i   (sipo_en),
    .bit_i  (bus.serial_in),
    .word_o (sipo_word),
    .busy_o (sipo_busy),
    .done_o (sipo_done)
  );

  always_comb begin
    slot_oh = '0;
    for (int i = 0; i < N_SLOTS; i++) slot_oh[i] = (addr_q == ADDR_W'(i));
    mask_d = mask_q | slot_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_out_q   <= '0;
      word_addr_q  <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      bank_q       <= '0;
      mask_q       <= '0;
    end else begin
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      ovf_q        <= ovf_q | bus.ovf_in;
      case (state_q)
        IDLE: begin
          if (bus.SL_in) begin
            addr_q  <= bus.a_in;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.SL_in) begin
            // a reload with bits already taken aborts the frame; back-to-back loads do not
            frame_err_q <= sipo_busy;
            addr_q      <= bus.a_in;
          end else if (sipo_done) begin
            word_out_q  <= sipo_word;
            word_addr_q <= addr_q;
            state_q     <= IDLE;
            if (addr_q < SLOT_LIM) begin
              word_valid_q <= 1'b1;
              for (int i = 0; i < N_SLOTS; i++)
                if (slot_oh[i]) bank_q[i] <= sipo_word;
              if (&mask_d) begin
                sweep_done_q <= 1'b1;
                mask_q       <= '0;
              end else begin
                mask_q <= mask_d;
              end
            end else begin
              addr_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (bus.rd_sel == ADDR_W'(i)) rd_d = bank_q[i];
  end

  assign bus.word_out   = word_out_q;
  assign bus.word_addr  = word_addr_q;
  assign bus.word_valid = word_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.rd_data    = rd_d;
  assign bus.ovf_seen   = ovf_q;
endmodule
